cube_sweep_engine: RTL and testbench
====================================

Name: cube_sweep_engine

Overview:
- Exhaustive stimulus/response stage for single-output combinational logic blocks from the optimized PLA benchmark set, such as the 19-input cube function.
- Upstream, it drives every N-bit input vector onto the block under evaluation, one per clock.
- Downstream, it samples the block's single output and accumulates the on-set size and the first on-set minterm.
- Used to cross-check optimized netlists against their original PLA functions on-chip or in simulation.

Parameters:
- N, 19, input vector width of the evaluated function (2..24).
- LAT, 0, pipeline latency in cycles from vec_o to the matching y_i (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a sweep.
- abort  in  1  single-cycle pulse; cancels a running sweep.
- vec_o  out  N  stimulus vector; bit i drives function input x<i>.
- y_i  in  1  function output for the vector presented LAT cycles earlier.
- busy  out  1  sweep in progress (RUN or DRAIN).
- done  out  1  sweep completed; level signal.
- hit_cnt  out  N+1  number of vectors with y_i=1.
- first_hit  out  N  lowest vector with y_i=1.
- first_hit_vld  out  1  first_hit is valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - vec_o=0, busy=0, done=0, hit_cnt=0, first_hit=0, first_hit_vld=0.
  - Valid delay line is cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, clear hit_cnt, first_hit and first_hit_vld, set vec_o=0, go to RUN.
  - busy goes high on the cycle after start.
- RUN:
  - Each cycle presents vec_o and pushes a valid tag plus vec_o copy into a LAT-deep delay line.
  - With LAT=0 the delay line is a wire: y_i is sampled against the current vec_o.
  - vec_o increments by 1 each cycle.
  - When vec_o = 2^N-1 has been presented: if LAT>0 go to DRAIN, else go to DONE.
  - vec_o holds at 2^N-1 after the last vector; it does not wrap.
- DRAIN:
  - No new vectors are tagged valid.
  - Stays exactly LAT cycles so the last LAT responses are sampled, then goes to DONE.
- Sampling rule: on each edge where the delayed valid tag is 1 and y_i=1:
  - hit_cnt increments by 1.
  - If first_hit_vld=0, first_hit takes the delayed vector and first_hit_vld is set to 1.
  - hit_cnt is N+1 bits wide and never saturates; the maximum value 2^N fits.
- DONE:
  - busy=0, done=1, results held.
  - start clears done in the same edge that enters RUN.
- Timing: the total sweep is 2^N + LAT cycles. done rises 2^N+LAT+1 cycles after the start pulse edge.
- start while busy=1: ignored.
- abort:
  - In RUN or DRAIN, returns to IDLE on the next edge.
  - done stays 0; hit_cnt and first_hit hold their partial values.
  - The delay line is cleared.
  - abort in IDLE or DONE is ignored.
- start and abort in the same cycle: in IDLE or DONE start wins; in RUN or DRAIN abort wins.
- Reset mid-sweep: immediate return to the reset values; no partial results are retained.
- y_i is ignored whenever the delayed valid tag is 0, including in IDLE, DONE and the cycles flushed by abort.

Optional Feature:
- Macro: CUBE_SWEEP_SIGNATURE_EN.
- When defined:
  - Adds output sig_o (16 bits), a MISR signature of the sampled response stream.
  - Polynomial x^16+x^12+x^5+1.
  - Each valid sample shifts in y_i: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ y_i.
  - Seeded to 16'hFFFF on start and on reset; holds in IDLE and DONE.
- When undefined: sig_o and the MISR logic are absent; all other behaviour is identical.

Test Plan:
- Cube, N=19, LAT=0: y_i = (vec_o == 19'h4C381), start -> after 524289 cycles done=1, hit_cnt=1, first_hit=19'h4C381, first_hit_vld=1.
- Constant 1, N=4, LAT=2: y_i tied high, start -> vec_o steps 0..15; done rises 19 cycles after start; hit_cnt=16, first_hit=0.
- Constant 0, N=4, LAT=3: y_i tied low -> done=1, hit_cnt=0, first_hit_vld=0.
- XOR of all bits, N=4, LAT=1, abort during the cycle vec_o=6 -> IDLE, done=0, hit_cnt=3 (hits at vectors 1, 2, 4), first_hit=1.
- Restart and same-cycle controls, N=4:
  - After done, pulse start -> done clears, results reset, second sweep matches the first.
  - start during busy is ignored.
  - start together with abort in RUN -> IDLE.
- rst_n low for 1 cycle while vec_o=9 mid-sweep -> all outputs 0 asynchronously; a later start produces a full, correct sweep.
- With CUBE_SWEEP_SIGNATURE_EN, the sig_o value from the XOR sweep matches the reference model.

Source files
------------

// File: rtl/cube_sweep_engine_if.sv
// cube_sweep_engine_if: stimulus/response and result bundle of the sweep engine.
// sig_o exists only when CUBE_SWEEP_SIGNATURE_EN is defined.
interface cube_sweep_engine_if #(
  parameter int N = 19
);
  logic         start;
  logic         abort;
  logic         y_i;
  logic [N-1:0] vec_o;
  logic         busy;
  logic         done;
  logic [N:0]   hit_cnt;
  logic [N-1:0] first_hit;
  logic         first_hit_vld;
`ifdef CUBE_SWEEP_SIGNATURE_EN
  logic [15:0]  sig_o;
  modport master (output start, abort, y_i,
                  input vec_o, busy, done, hit_cnt, first_hit, first_hit_vld, sig_o);
  modport slave (input start, abort, y_i,
                 output vec_o, busy, done, hit_cnt, first_hit, first_hit_vld, sig_o);
`else
  modport master (output start, abort, y_i,
                  input vec_o, busy, done, hit_cnt, first_hit, first_hit_vld);
  modport slave (input start, abort, y_i,
                 output vec_o, busy, done, hit_cnt, first_hit, first_hit_vld);
`endif
endinterface

// File: rtl/cube_sweep_engine.sv
// cube_sweep_engine: drives all 2^N input vectors, counts on-set size and lowest on-set minterm.
// Defining CUBE_SWEEP_SIGNATURE_EN adds a 16-bit MISR signature of the response stream on sig_o.
module cube_sweep_engine #(
  parameter int N   = 19,
  parameter int LAT = 0
) (
  input logic                clk,
  input logic                rst_n,
  cube_sweep_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [N:0] ONE = 1;
  state_t state, state_d;
  logic [N-1:0] vec, first, tap_vec;
  logic [N:0] hit;
  logic [1:0] dcnt;
  logic fvld, tap_vld, busy, idle, last, flush, go, smp, push, drain_end;
  assign busy = state == RUN || state == DRAIN;
  assign idle = state == IDLE || state == DONE;
  assign last = vec == {N{1'b1}};
  assign flush = busy && bus.abort;
  assign go = idle && bus.start;
  assign push = state == RUN;
  assign smp = tap_vld && !flush;
  assign drain_end = dcnt == 2'(LAT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = flush ? IDLE :
              go ? RUN :
              push && last ? (LAT == 0 ? DONE : DRAIN) :
              state == DRAIN && drain_end ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dcnt <= 2'd0;
    else dcnt <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
  // Response delay line: tags and vector copies line up with y_i LAT cycles later
  generate
    if (LAT == 0) begin : g_wire
      assign tap_vld = push;
      assign tap_vec = vec;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [N-1:0] vec_q [LAT];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vld_q <= '0;
        else vld_q <= flush ? '0 : LAT'({vld_q, push});
      always_ff @(posedge clk) begin
        vec_q[0] <= vec;
        for (int i = 1; i < LAT; i++) vec_q[i] <= vec_q[i-1];
      end
      assign tap_vld = vld_q[LAT-1];
      assign tap_vec = vec_q[LAT-1];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec <= '0;
      hit <= '0;
      first <= '0;
      fvld <= 1'b0;
    end else if (go) begin
      vec <= '0;
      hit <= '0;
      first <= '0;
      fvld <= 1'b0;
    end else begin
      if (push && !last && !flush) vec <= vec + N'(1);
      if (smp && bus.y_i) begin
        hit <= hit + ONE;
        fvld <= 1'b1;
        if (!fvld) first <= tap_vec;
      end
    end
`ifdef CUBE_SWEEP_SIGNATURE_EN
  logic [15:0] sig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= 16'hFFFF;
    else if (go) sig <= 16'hFFFF;
    else if (smp) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'd0, bus.y_i};
  assign bus.sig_o = sig;
`endif
  assign bus.vec_o = vec;
  assign bus.busy = busy;
  assign bus.done = state == DONE;
  assign bus.hit_cnt = hit;
  assign bus.first_hit = first;
  assign bus.first_hit_vld = fvld;
endmodule

// File: tb/tb_cube_sweep_engine.sv
// tb_cube_sweep_engine: four engines (N/LAT = 10/0, 4/1, 4/3, 4/2) sweeping shared functions,
// checked against hand tables and a counting reference model.
module tb_cube_sweep_engine;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  int mode = 0;
  logic [15:0] tt = '0;
  logic [9:0] cm = '0, cc = '0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  cube_sweep_engine_if #(.N(10)) b0 ();
  cube_sweep_engine_if #(.N(4)) b1 ();
  cube_sweep_engine_if #(.N(4)) b2 ();
  cube_sweep_engine_if #(.N(4)) b3 ();
  cube_sweep_engine #(.N(10), .LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  cube_sweep_engine #(.N(4), .LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  cube_sweep_engine #(.N(4), .LAT(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  cube_sweep_engine #(.N(4), .LAT(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  function automatic bit fy(input int md, input logic [15:0] t, input logic [9:0] m,
                            input logic [9:0] c, input int n, input int v);
    logic [9:0] x;
    x = v[9:0];
    if (md == 0) return 1'b0;
    if (md == 1) return 1'b1;
    if (md == 2) return ^x;
    return n == 4 ? t[x[3:0]] : (x & m) == c;
  endfunction

  // The evaluated blocks: pipelined by LAT stages in front of each engine
  logic [3:0] q1;
  logic [3:0] q2 [3];
  logic [3:0] q3 [2];
  always @(posedge clk) begin
    q1 <= b1.vec_o;
    q2[0] <= b2.vec_o;
    q2[1] <= q2[0];
    q2[2] <= q2[1];
    q3[0] <= b3.vec_o;
    q3[1] <= q3[0];
  end
  assign b0.y_i = fy(mode, tt, cm, cc, 10, int'(b0.vec_o));
  assign b1.y_i = fy(mode, tt, cm, cc, 4, int'(q1));
  assign b2.y_i = fy(mode, tt, cm, cc, 4, int'(q2[2]));
  assign b3.y_i = fy(mode, tt, cm, cc, 4, int'(q3[1]));
  assign b0.start = start;
  assign b1.start = start;
  assign b2.start = start;
  assign b3.start = start;
  assign b0.abort = abort;
  assign b1.abort = abort;
  assign b2.abort = abort;
  assign b3.abort = abort;

  logic [15:0] sg0, sg1, sg2, sg3;
`ifdef CUBE_SWEEP_SIGNATURE_EN
  assign sg0 = b0.sig_o;
  assign sg1 = b1.sig_o;
  assign sg2 = b2.sig_o;
  assign sg3 = b3.sig_o;
`else
  assign sg0 = '0;
  assign sg1 = '0;
  assign sg2 = '0;
  assign sg3 = '0;
`endif

  task automatic cmp(input string t, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", t, act, exp);
    end
  endtask

  // Reference: responses of vectors 0..lim-1 in order, counted and folded into the MISR
  task automatic model(input int n, input int lim, output int h, output int f, output int vl, output int s);
    bit y;
    h = 0; f = 0; vl = 0; s = 'hFFFF;
    for (int v = 0; v < lim; v++) begin
      y = fy(mode, tt, cm, cc, n, v);
      if (y && vl == 0) begin
        f = v;
        vl = 1;
      end
      h += int'(y);
      s = ((s << 1) & 'hFFFF) ^ (s[15] ? 'h1021 : 0) ^ int'(y);
    end
  endtask

  task automatic check_one(input string t, input int n, input int lat, input int a,
                           input int ha, input int fa, input int va, input int sa);
    int lim, h, f, vl, s;
    lim = a < 0 ? (1 << n) : (a > lat ? a - lat : 0);
    model(n, lim, h, f, vl, s);
    cmp({t, ".hit"}, ha, h);
    cmp({t, ".first"}, fa, f);
    cmp({t, ".vld"}, va, vl);
`ifdef CUBE_SWEEP_SIGNATURE_EN
    cmp({t, ".sig"}, sa, s);
`endif
  endtask

  task automatic check_all(input string t, input int a);
    check_one({t, ".d0"}, 10, 0, a, int'(b0.hit_cnt), int'(b0.first_hit), int'(b0.first_hit_vld), int'(sg0));
    check_one({t, ".d1"}, 4, 1, a, int'(b1.hit_cnt), int'(b1.first_hit), int'(b1.first_hit_vld), int'(sg1));
    check_one({t, ".d2"}, 4, 3, a, int'(b2.hit_cnt), int'(b2.first_hit), int'(b2.first_hit_vld), int'(sg2));
    check_one({t, ".d3"}, 4, 2, a, int'(b3.hit_cnt), int'(b3.first_hit), int'(b3.first_hit_vld), int'(sg3));
  endtask

  task automatic check_status(input string t, input int bsy, input int dn);
    cmp({t, ".busy0"}, int'(b0.busy), bsy);
    cmp({t, ".busy1"}, int'(b1.busy), bsy);
    cmp({t, ".busy2"}, int'(b2.busy), bsy);
    cmp({t, ".busy3"}, int'(b3.busy), bsy);
    cmp({t, ".done0"}, int'(b0.done), dn);
    cmp({t, ".done1"}, int'(b1.done), dn);
    cmp({t, ".done2"}, int'(b2.done), dn);
    cmp({t, ".done3"}, int'(b3.done), dn);
  endtask

  task automatic check_zero(input string t);
    check_status(t, 0, 0);
    cmp({t, ".vec0"}, int'(b0.vec_o), 0);
    cmp({t, ".vec1"}, int'(b1.vec_o), 0);
    cmp({t, ".hit0"}, int'(b0.hit_cnt), 0);
    cmp({t, ".hit1"}, int'(b1.hit_cnt), 0);
    cmp({t, ".first0"}, int'(b0.first_hit), 0);
    cmp({t, ".first1"}, int'(b1.first_hit), 0);
    cmp({t, ".vld0"}, int'(b0.first_hit_vld), 0);
    cmp({t, ".vld1"}, int'(b1.first_hit_vld), 0);
`ifdef CUBE_SWEEP_SIGNATURE_EN
    cmp({t, ".sig1"}, int'(b1.sig_o), 'hFFFF);
`endif
  endtask

  // Full sweep from IDLE/DONE; optional ignored start mid-run and abort alongside start
  task automatic run_sweep(input string t, input bit mid_start, input bit with_abort);
    int dc[4];
    int vbad;
    dc = '{default: 0};
    vbad = 0;
    start = 1'b1;
    abort = with_abort;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (k == 1) begin
        check_status({t, ".k1"}, 1, 0);
        cmp({t, ".k1.hit"}, int'(b1.hit_cnt), 0);
        cmp({t, ".k1.vld"}, int'(b2.first_hit_vld), 0);
      end
      if (int'(b3.vec_o) != (k > 16 ? 15 : k - 1)) vbad++;
      if (dc[0] == 0 && b0.done) dc[0] = k;
      if (dc[1] == 0 && b1.done) dc[1] = k;
      if (dc[2] == 0 && b2.done) dc[2] = k;
      if (dc[3] == 0 && b3.done) dc[3] = k;
      if (mid_start && k == 5) start = 1'b1;
      if (dc[0] != 0 && dc[1] != 0 && dc[2] != 0 && dc[3] != 0) break;
    end
    cmp({t, ".vec_seq"}, vbad, 0);
    cmp({t, ".done_cyc0"}, dc[0], 1025);
    cmp({t, ".done_cyc1"}, dc[1], 18);
    cmp({t, ".done_cyc2"}, dc[2], 20);
    cmp({t, ".done_cyc3"}, dc[3], 19);
    check_status({t, ".end"}, 0, 1);
  endtask

  task automatic run_abort(input string t, input int a, input bit ws);
    start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (b1.busy && int'(b1.vec_o) == a) break;
    end
    cmp({t, ".reach"}, int'(b1.vec_o), a);
    abort = 1'b1;
    start = ws;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check_status({t, ".after"}, 0, 0);
    check_all(t, a);
    repeat (3) @(posedge clk);
    #1;
    check_status({t, ".idle"}, 0, 0);
  endtask

  typedef struct {
    int md;
    logic [15:0] t;
    logic [9:0] m, c;
    int h4, f4, v4, h10, f10, v10;
  } rec_t;

  initial begin
    rec_t tab[6];
    string nm;
    tab[0] = '{0, 16'h0000, 10'h000, 10'h000, 0, 0, 0, 0, 0, 0};
    tab[1] = '{1, 16'h0000, 10'h000, 10'h000, 16, 0, 1, 1024, 0, 1};
    tab[2] = '{2, 16'h0000, 10'h000, 10'h000, 8, 1, 1, 512, 1, 1};
    tab[3] = '{3, 16'h8000, 10'h3FF, 10'h2C5, 1, 15, 1, 1, 709, 1};
    tab[4] = '{3, 16'h0030, 10'h0F0, 10'h0A0, 2, 4, 1, 64, 160, 1};
    tab[5] = '{2, 16'h0000, 10'h000, 10'h000, 8, 1, 1, 512, 1, 1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_zero("reset");
    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("tab%0d", i);
      mode = tab[i].md;
      tt = tab[i].t;
      cm = tab[i].m;
      cc = tab[i].c;
      run_sweep(nm, i == 2, i == 3);
      cmp({nm, ".d0.hit_tab"}, int'(b0.hit_cnt), tab[i].h10);
      cmp({nm, ".d0.first_tab"}, int'(b0.first_hit), tab[i].f10);
      cmp({nm, ".d0.vld_tab"}, int'(b0.first_hit_vld), tab[i].v10);
      cmp({nm, ".d1.hit_tab"}, int'(b1.hit_cnt), tab[i].h4);
      cmp({nm, ".d2.hit_tab"}, int'(b2.hit_cnt), tab[i].h4);
      cmp({nm, ".d3.hit_tab"}, int'(b3.hit_cnt), tab[i].h4);
      cmp({nm, ".d3.first_tab"}, int'(b3.first_hit), tab[i].f4);
      cmp({nm, ".d2.vld_tab"}, int'(b2.first_hit_vld), tab[i].v4);
      check_all(nm, -1);
    end
    for (int i = 0; i < 3; i++) begin
      mode = 3;
      tt = 16'($urandom);
      cm = 10'($urandom);
      cc = 10'($urandom) & cm;
      nm = $sformatf("rnd%0d", i);
      run_sweep(nm, 1'b0, 1'b0);
      check_all(nm, -1);
    end
    mode = 2;
    run_abort("abort6", 6, 1'b0);
    cmp("abort6.d1.hit_hand", int'(b1.hit_cnt), 3);
    cmp("abort6.d1.first_hand", int'(b1.first_hit), 1);
    mode = 3;
    tt = 16'($urandom);
    cm = 10'($urandom);
    cc = 10'($urandom) & cm;
    run_abort("abort_start", 9, 1'b1);
    mode = 2;
    run_sweep("idle_sa", 1'b0, 1'b1);
    check_all("idle_sa", -1);
    start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (b1.busy && int'(b1.vec_o) == 9) break;
    end
    cmp("rst.reach", int'(b1.vec_o), 9);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_sweep("post_rst", 1'b0, 1'b0);
    check_all("post_rst", -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
